hls_loop_status_monitor: RTL and testbench
==========================================

// Module: hls_loop_status_monitor
// PURPOSE
//  Synthesizable activity monitor beside an HLS kernel (e.g. the dft top) in simulation/bring-up builds.
//  Module side: ap_start/ap_ready/ap_done handshake -> transaction count, latency, busy state.
//  Loop side: kernel FSM and pipeline enables -> iterations started/ended/in flight, stalls, invocations.
//  All statistics freeze once `finish` is seen.
// PARAMETERS
//  STATE_W  1   width of kernel FSM state vector (cur_state and *_state inputs)
//  CNT_W    32  width of every counter/latency output
// PORTS
//  clock              in   1        single clock, all logic on rising edge
//  reset              in   1        synchronous, active-low (0 = reset)
//  ap_start           in   1        kernel start
//  ap_ready           in   1        kernel ready
//  ap_done            in   1        kernel done
//  ap_continue        in   1        kernel continue (tie 1 if absent)
//  finish             in   1        end of test; freezes monitor
//  cur_state          in   STATE_W  kernel ap_CS_fsm
//  iter_start_state   in   STATE_W  state in which an iteration starts
//  iter_end_state     in   STATE_W  state in which an iteration ends
//  quit_state         in   STATE_W  state in which the loop exits
//  iter_start_block   in   1        stage subdone-block at start state
//  iter_end_block     in   1        stage subdone-block at end state
//  quit_block         in   1        stage subdone-block at quit state
//  iter_start_enable  in   1        pipeline iter0 enable
//  iter_end_enable    in   1        last pipeline iter enable
//  quit_enable        in   1        last pipeline iter enable at quit
//  loop_start/loop_ready/loop_done/loop_continue  in 1 each  loop-level handshake
//  quit_at_end        in   1        1: loop exits after last iteration completes
//  txn_active         out  1        kernel transaction in progress
//  txn_cnt            out  CNT_W    completed kernel transactions
//  last_txn_lat       out  CNT_W    latency of most recent transaction
//  max_txn_lat        out  CNT_W    largest transaction latency
//  loop_active        out  1        loop invocation in progress
//  loop_inv_cnt       out  CNT_W    completed loop invocations
//  iter_start_cnt     out  CNT_W    iterations started
//  iter_end_cnt       out  CNT_W    iterations ended
//  iters_in_flight    out  CNT_W    started minus ended, current invocation
//  stall_cnt          out  CNT_W    blocked cycles while loop_active
//  frozen             out  1        finish seen
//  protocol_err       out  1        sticky; illegal event observed
// BEHAVIOUR
//  - reset==0 at a clock edge: every output and internal register cleared to 0 (incl. frozen, protocol_err).
//  - frozen: set the cycle after finish==1 is sampled; while frozen no output changes until reset.
//  - txn start: ap_start & !txn_active. txn end: txn_active-or-start & ap_done & ap_continue.
//  - latency: cycles from start cycle to done cycle inclusive; start and done same cycle -> latency 1,
//    txn_cnt+1, txn_active stays 0. Outputs update the cycle after the event (registered, 1-cycle latency).
//  - max_txn_lat updated when new latency > stored value.
//  - iter start ev: cur_state==iter_start_state & !iter_start_block & iter_start_enable (full-width compare).
//  - iter end ev:   cur_state==iter_end_state & !iter_end_block & iter_end_enable.
//  - quit ev:       cur_state==quit_state & !quit_block & quit_enable & quit_at_end.
//  - same-cycle start+end: both counters +1, iters_in_flight unchanged.
//  - end ev with iters_in_flight==0 (and no same-cycle start): ignored, protocol_err set.
//  - loop_active set on loop_start & !loop_active; cleared on loop_done & loop_continue, or on quit ev;
//    clear wins over set in same cycle. loop_inv_cnt +1 on clear; iters_in_flight!=0 at clear -> protocol_err,
//    then iters_in_flight reset to 0.
//  - stall: loop_active & cur_state==iter_start_state & iter_start_block -> stall_cnt+1.
//  - ap_done while !txn_active & !ap_start -> protocol_err.
//  - all counters saturate at 2^CNT_W-1 (no wrap); latency counter saturates likewise.
// STRUCTURE
//  - package loop_mon_pkg: CNT_W default localparam, cnt_t typedef, sat_inc() function.
//  - one sub-module: mon_sat_counter (en, clr, q; saturating, sync active-low reset, freeze input).
//  - top: two small FSMs (TXN IDLE/BUSY, LOOP IDLE/ACTIVE) plus event decode; no memories.
// TESTING
//  - reset=0 2 cycles with inputs toggling -> all outputs 0; release -> still 0 until events.
//  - ap_start cycle 0, ap_done+continue cycle 9 -> txn_cnt=1, last_txn_lat=10, max=10; 2nd txn lat 4 -> max stays 10.
//  - ap_start & ap_done same cycle -> txn_cnt+1, last_txn_lat=1, txn_active never 1.
//  - loop of 32 iters, depth 34, 3 blocked cycles -> iter_start_cnt=32, iter_end_cnt=32, stall_cnt=3, loop_inv_cnt=1, in_flight=0.
//  - end event with in_flight=0 -> protocol_err=1, iter_end_cnt unchanged; persists until reset.
//  - finish=1 mid-transaction, further events -> frozen=1, all counters hold; CNT_W=4 with 20 iters -> iter_start_cnt=15.

Source files
------------

// File: rtl/loop_mon_pkg.sv
// Shared types and helpers for the HLS loop/transaction status monitor.
package loop_mon_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

    typedef enum logic [0:0] {
        TXN_IDLE = 1'b0,
        TXN_BUSY = 1'b1
    } txn_state_t;

    typedef enum logic [0:0] {
        LOOP_IDLE   = 1'b0,
        LOOP_ACTIVE = 1'b1
    } loop_state_t;

    // Saturating increment: sticks at max_v instead of wrapping to zero.
    function automatic cnt_t sat_inc(input cnt_t v, input cnt_t max_v);
        cnt_t r;
        if (v >= max_v) begin
            r = max_v;
        end else begin
            r = v + cnt_t'(1'b1);
        end
        return r;
    endfunction

endpackage

// File: rtl/mon_sat_counter.sv
// Saturating event counter with synchronous active-low reset, freeze and clear.
// Widths up to CNT_W_DEFAULT are supported (the shared helper works on cnt_t).
module mon_sat_counter
    import loop_mon_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         freeze,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam cnt_t MAX_V = cnt_t'({W{1'b1}});

    logic [W-1:0] q_r;

    // Counter register: reset, hold while frozen, clear, or count with saturation.
    always_ff @(posedge clock) begin
        if (!reset) begin
            q_r <= {W{1'b0}};
        end else if (freeze) begin
            q_r <= q_r;
        end else if (clr) begin
            q_r <= {W{1'b0}};
        end else if (en) begin
            q_r <= W'(sat_inc(cnt_t'(q_r), MAX_V));
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/hls_loop_status_monitor.sv
// Activity monitor for an HLS kernel: kernel-level handshake statistics and
// loop-level iteration/stall/invocation statistics, all frozen at end of test.
module hls_loop_status_monitor
    import loop_mon_pkg::*;
#(
    parameter int STATE_W = 1,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic               finish,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    output logic               txn_active,
    output logic [CNT_W-1:0]   txn_cnt,
    output logic [CNT_W-1:0]   last_txn_lat,
    output logic [CNT_W-1:0]   max_txn_lat,
    output logic               loop_active,
    output logic [CNT_W-1:0]   loop_inv_cnt,
    output logic [CNT_W-1:0]   iter_start_cnt,
    output logic [CNT_W-1:0]   iter_end_cnt,
    output logic [CNT_W-1:0]   iters_in_flight,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               frozen,
    output logic               protocol_err
);

    localparam cnt_t MAX_C = cnt_t'({CNT_W{1'b1}});

    function automatic logic [CNT_W-1:0] inc_c(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(cnt_t'(v), MAX_C));
    endfunction

    txn_state_t       txn_state_r;
    txn_state_t       txn_state_nxt_s;
    loop_state_t      loop_state_r;
    loop_state_t      loop_state_nxt_s;
    logic [CNT_W-1:0] lat_r;
    logic [CNT_W-1:0] last_lat_r;
    logic [CNT_W-1:0] max_lat_r;
    logic [CNT_W-1:0] in_flight_r;
    logic [CNT_W-1:0] in_flight_nxt_s;
    logic [CNT_W-1:0] cur_lat_s;
    logic             frozen_r;
    logic             perr_r;

    logic hold_s;
    logic txn_active_s;
    logic txn_start_s;
    logic txn_end_s;
    logic ap_err_s;
    logic loop_active_s;
    logic iter_start_ev_s;
    logic iter_end_ev_s;
    logic quit_ev_s;
    logic end_ok_s;
    logic end_err_s;
    logic loop_set_s;
    logic loop_clr_s;
    logic loop_err_s;
    logic stall_s;
    logic unused_s;

    // Ready strobes carry no information the monitor needs.
    assign unused_s = ap_ready ^ loop_ready;

    // Statistics stop updating on the cycle finish is sampled and stay put afterwards.
    assign hold_s = frozen_r | finish;

    // Kernel handshake decode.
    assign txn_active_s = (txn_state_r == TXN_BUSY);
    assign txn_start_s  = ap_start & ~txn_active_s;
    assign txn_end_s    = (txn_active_s | txn_start_s) & ap_done & ap_continue;
    assign ap_err_s     = ap_done & ~txn_active_s & ~ap_start;
    // Start cycle counts as cycle 1; each busy cycle adds one.
    assign cur_lat_s    = txn_active_s ? inc_c(lat_r) : CNT_W'(1'b1);

    // Loop event decode (full-width state compares).
    assign loop_active_s   = (loop_state_r == LOOP_ACTIVE);
    assign iter_start_ev_s = (cur_state == iter_start_state) & ~iter_start_block & iter_start_enable;
    assign iter_end_ev_s   = (cur_state == iter_end_state) & ~iter_end_block & iter_end_enable;
    assign quit_ev_s       = (cur_state == quit_state) & ~quit_block & quit_enable & quit_at_end;
    // An end with nothing in flight is only legal when an iteration starts alongside it.
    assign end_ok_s        = iter_end_ev_s & (iter_start_ev_s | (in_flight_r != {CNT_W{1'b0}}));
    assign end_err_s       = iter_end_ev_s & ~end_ok_s;
    assign loop_set_s      = loop_start & ~loop_active_s;
    // A clear only closes an invocation that is open or opening this cycle.
    assign loop_clr_s      = ((loop_done & loop_continue) | quit_ev_s) & (loop_active_s | loop_set_s);
    assign loop_err_s      = loop_clr_s & (in_flight_nxt_s != {CNT_W{1'b0}});
    assign stall_s         = loop_active_s & (cur_state == iter_start_state) & iter_start_block;

    // Transaction FSM next state.
    always_comb begin
        txn_state_nxt_s = txn_state_r;
        case (txn_state_r)
            TXN_IDLE: begin
                if (txn_start_s & ~txn_end_s) begin
                    txn_state_nxt_s = TXN_BUSY;
                end else begin
                    txn_state_nxt_s = TXN_IDLE;
                end
            end
            TXN_BUSY: begin
                if (txn_end_s) begin
                    txn_state_nxt_s = TXN_IDLE;
                end else begin
                    txn_state_nxt_s = TXN_BUSY;
                end
            end
            default: txn_state_nxt_s = TXN_IDLE;
        endcase
    end

    // Loop FSM next state; a clear beats a set in the same cycle.
    always_comb begin
        loop_state_nxt_s = loop_state_r;
        case (loop_state_r)
            LOOP_IDLE: begin
                if (loop_set_s & ~loop_clr_s) begin
                    loop_state_nxt_s = LOOP_ACTIVE;
                end else begin
                    loop_state_nxt_s = LOOP_IDLE;
                end
            end
            LOOP_ACTIVE: begin
                if (loop_clr_s) begin
                    loop_state_nxt_s = LOOP_IDLE;
                end else begin
                    loop_state_nxt_s = LOOP_ACTIVE;
                end
            end
            default: loop_state_nxt_s = LOOP_IDLE;
        endcase
    end

    // In-flight count after this cycle's start/end events.
    always_comb begin
        in_flight_nxt_s = in_flight_r;
        if (iter_start_ev_s & ~end_ok_s) begin
            in_flight_nxt_s = inc_c(in_flight_r);
        end else if (end_ok_s & ~iter_start_ev_s) begin
            in_flight_nxt_s = in_flight_r - CNT_W'(1'b1);
        end else begin
            in_flight_nxt_s = in_flight_r;
        end
    end

    // FSM states, latency tracking, in-flight count and sticky flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            txn_state_r  <= TXN_IDLE;
            loop_state_r <= LOOP_IDLE;
            lat_r        <= {CNT_W{1'b0}};
            last_lat_r   <= {CNT_W{1'b0}};
            max_lat_r    <= {CNT_W{1'b0}};
            in_flight_r  <= {CNT_W{1'b0}};
            frozen_r     <= 1'b0;
            perr_r       <= 1'b0;
        end else if (hold_s) begin
            frozen_r <= 1'b1;
        end else begin
            txn_state_r  <= txn_state_nxt_s;
            loop_state_r <= loop_state_nxt_s;
            if (txn_start_s) begin
                lat_r <= CNT_W'(1'b1);
            end else if (txn_active_s) begin
                lat_r <= inc_c(lat_r);
            end else begin
                lat_r <= lat_r;
            end
            if (txn_end_s) begin
                last_lat_r <= cur_lat_s;
                if (cur_lat_s > max_lat_r) begin
                    max_lat_r <= cur_lat_s;
                end else begin
                    max_lat_r <= max_lat_r;
                end
            end else begin
                last_lat_r <= last_lat_r;
            end
            if (loop_clr_s) begin
                in_flight_r <= {CNT_W{1'b0}};
            end else begin
                in_flight_r <= in_flight_nxt_s;
            end
            if (ap_err_s | end_err_s | loop_err_s) begin
                perr_r <= 1'b1;
            end else begin
                perr_r <= perr_r;
            end
        end
    end

    mon_sat_counter #(.W(CNT_W)) u_txn_cnt (
        .clock(clock), .reset(reset), .freeze(hold_s), .clr(1'b0), .en(txn_end_s), .q(txn_cnt)
    );
    mon_sat_counter #(.W(CNT_W)) u_loop_inv_cnt (
        .clock(clock), .reset(reset), .freeze(hold_s), .clr(1'b0), .en(loop_clr_s), .q(loop_inv_cnt)
    );
    mon_sat_counter #(.W(CNT_W)) u_iter_start_cnt (
        .clock(clock), .reset(reset), .freeze(hold_s), .clr(1'b0), .en(iter_start_ev_s), .q(iter_start_cnt)
    );
    mon_sat_counter #(.W(CNT_W)) u_iter_end_cnt (
        .clock(clock), .reset(reset), .freeze(hold_s), .clr(1'b0), .en(end_ok_s), .q(iter_end_cnt)
    );
    mon_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock(clock), .reset(reset), .freeze(hold_s), .clr(1'b0), .en(stall_s), .q(stall_cnt)
    );

    assign txn_active      = txn_active_s;
    assign last_txn_lat    = last_lat_r;
    assign max_txn_lat     = max_lat_r;
    assign loop_active     = loop_active_s;
    assign iters_in_flight = in_flight_r;
    assign frozen          = frozen_r;
    assign protocol_err    = perr_r;

endmodule

// File: tb/tb_hls_loop_status_monitor.sv
// Scoreboard bench for hls_loop_status_monitor: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_hls_loop_status_monitor;

    localparam int STATE_W = 1;
    localparam int CNT_W   = 32;
    localparam int CNT_W4  = 4;

    localparam int S_TXN_ACTIVE  = 0;
    localparam int S_TXN_CNT     = 1;
    localparam int S_LAST_LAT    = 2;
    localparam int S_MAX_LAT     = 3;
    localparam int S_LOOP_ACTIVE = 4;
    localparam int S_LOOP_INV    = 5;
    localparam int S_ITER_START  = 6;
    localparam int S_ITER_END    = 7;
    localparam int S_IN_FLIGHT   = 8;
    localparam int S_STALL       = 9;
    localparam int S_FROZEN      = 10;
    localparam int S_PERR        = 11;
    localparam int S_W4_START    = 12;
    localparam int S_LATQ_LEFT   = 13;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ap_start, ap_ready, ap_done, ap_continue, finish;
    logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
    logic iter_start_block, iter_end_block, quit_block;
    logic iter_start_enable, iter_end_enable, quit_enable;
    logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;

    logic             txn_active, loop_active, frozen, protocol_err;
    logic [CNT_W-1:0] txn_cnt, last_txn_lat, max_txn_lat, loop_inv_cnt;
    logic [CNT_W-1:0] iter_start_cnt, iter_end_cnt, iters_in_flight, stall_cnt;

    logic              w4_txn_active, w4_loop_active, w4_frozen, w4_protocol_err;
    logic [CNT_W4-1:0] w4_txn_cnt, w4_last_txn_lat, w4_max_txn_lat, w4_loop_inv_cnt;
    logic [CNT_W4-1:0] w4_iter_start_cnt, w4_iter_end_cnt, w4_iters_in_flight, w4_stall_cnt;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [31:0] lat_q[$];
    int          checks = 0;
    int          errors = 0;
    int          req_cnt = 0;
    int          ack_cnt = 0;
    logic [31:0] prev_txn_cnt = 32'd0;

    always #5 clock = ~clock;

    hls_loop_status_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .finish(finish), .cur_state(cur_state),
        .iter_start_state(iter_start_state), .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .txn_active(txn_active), .txn_cnt(txn_cnt), .last_txn_lat(last_txn_lat), .max_txn_lat(max_txn_lat),
        .loop_active(loop_active), .loop_inv_cnt(loop_inv_cnt), .iter_start_cnt(iter_start_cnt),
        .iter_end_cnt(iter_end_cnt), .iters_in_flight(iters_in_flight), .stall_cnt(stall_cnt),
        .frozen(frozen), .protocol_err(protocol_err)
    );

    hls_loop_status_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W4)) dut4 (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .finish(finish), .cur_state(cur_state),
        .iter_start_state(iter_start_state), .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .txn_active(w4_txn_active), .txn_cnt(w4_txn_cnt), .last_txn_lat(w4_last_txn_lat),
        .max_txn_lat(w4_max_txn_lat), .loop_active(w4_loop_active), .loop_inv_cnt(w4_loop_inv_cnt),
        .iter_start_cnt(w4_iter_start_cnt), .iter_end_cnt(w4_iter_end_cnt),
        .iters_in_flight(w4_iters_in_flight), .stall_cnt(w4_stall_cnt),
        .frozen(w4_frozen), .protocol_err(w4_protocol_err)
    );

    function automatic logic [31:0] actual(input int sig);
        logic [31:0] v;
        case (sig)
            S_TXN_ACTIVE:  v = {31'd0, txn_active};
            S_TXN_CNT:     v = txn_cnt;
            S_LAST_LAT:    v = last_txn_lat;
            S_MAX_LAT:     v = max_txn_lat;
            S_LOOP_ACTIVE: v = {31'd0, loop_active};
            S_LOOP_INV:    v = loop_inv_cnt;
            S_ITER_START:  v = iter_start_cnt;
            S_ITER_END:    v = iter_end_cnt;
            S_IN_FLIGHT:   v = iters_in_flight;
            S_STALL:       v = stall_cnt;
            S_FROZEN:      v = {31'd0, frozen};
            S_PERR:        v = {31'd0, protocol_err};
            S_W4_START:    v = {28'd0, w4_iter_start_cnt};
            S_LATQ_LEFT:   v = 32'(lat_q.size());
            default:       v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    // Monitor: transaction scoreboard on every txn_cnt change, plus queued checkpoints.
    initial begin : monitor
        logic [31:0] exp_lat;
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                prev_txn_cnt = txn_cnt;
            end else if (txn_cnt !== prev_txn_cnt) begin
                checks++;
                if (txn_cnt !== prev_txn_cnt + 32'd1) begin
                    errors++;
                    $display("FAIL txn_cnt_step: got %0d expected %0d", txn_cnt, prev_txn_cnt + 32'd1);
                end
                checks++;
                if (lat_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_txn: txn_cnt became %0d with no transaction queued", txn_cnt);
                end else begin
                    exp_lat = lat_q.pop_front();
                    if (last_txn_lat !== exp_lat) begin
                        errors++;
                        $display("FAIL last_txn_lat: got %0d expected %0d", last_txn_lat, exp_lat);
                    end
                end
                prev_txn_cnt = txn_cnt;
            end
            if (ack_cnt != req_cnt) begin
                while (chk_q.size() > 0) begin
                    c   = chk_q.pop_front();
                    act = actual(c.sig);
                    checks++;
                    if (act !== c.exp) begin
                        errors++;
                        $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
                    end
                end
                ack_cnt = req_cnt;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_val(input string name, input int sig, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sig  = sig;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic checkpoint();
        bit done;
        done = 1'b0;
        req_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (!done) begin
                @(negedge clock);
                #1;
                if (ack_cnt == req_cnt) done = 1'b1;
            end
        end
        if (!done) begin
            $display("FAIL checkpoint_timeout: ack %0d expected %0d", ack_cnt, req_cnt);
            $fatal(1, "checkpoint not serviced");
        end
    endtask

    task automatic idle();
        ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b1; finish = 1'b0;
        cur_state = 1'b0; iter_start_state = 1'b1; iter_end_state = 1'b1; quit_state = 1'b1;
        iter_start_block = 1'b0; iter_end_block = 1'b0; quit_block = 1'b0;
        iter_start_enable = 1'b0; iter_end_enable = 1'b0; quit_enable = 1'b0;
        loop_start = 1'b0; loop_ready = 1'b0; loop_done = 1'b0; loop_continue = 1'b1; quit_at_end = 1'b1;
    endtask

    task automatic expect_all_zero(input string tag);
        expect_val({tag, "_txn_active"}, S_TXN_ACTIVE, 32'd0);
        expect_val({tag, "_txn_cnt"}, S_TXN_CNT, 32'd0);
        expect_val({tag, "_last_lat"}, S_LAST_LAT, 32'd0);
        expect_val({tag, "_max_lat"}, S_MAX_LAT, 32'd0);
        expect_val({tag, "_loop_active"}, S_LOOP_ACTIVE, 32'd0);
        expect_val({tag, "_loop_inv"}, S_LOOP_INV, 32'd0);
        expect_val({tag, "_iter_start"}, S_ITER_START, 32'd0);
        expect_val({tag, "_iter_end"}, S_ITER_END, 32'd0);
        expect_val({tag, "_in_flight"}, S_IN_FLIGHT, 32'd0);
        expect_val({tag, "_stall"}, S_STALL, 32'd0);
        expect_val({tag, "_frozen"}, S_FROZEN, 32'd0);
        expect_val({tag, "_perr"}, S_PERR, 32'd0);
        expect_val({tag, "_w4_iter_start"}, S_W4_START, 32'd0);
        checkpoint();
    endtask

    // Pipelined loop: n iterations, each ending depth-1 pipeline steps after it
    // starts; stall cycles are inserted before pipeline steps s1/s2/s3.
    task automatic run_loop(input int n, input int depth, input int s1, input int s2, input int s3,
                            input bit use_quit, input int mid_pt, input int mid_stalls);
        int last_pt;
        int k;
        int ends;
        loop_start = 1'b1;
        step();
        loop_start  = 1'b0;
        quit_at_end = use_quit;
        last_pt = n + depth - 2;
        for (int pt = 0; pt <= last_pt; pt++) begin
            k = int'(s1 == pt) + int'(s2 == pt) + int'(s3 == pt);
            cur_state         = 1'b1;
            iter_start_enable = (pt < n);
            iter_end_enable   = (pt >= depth - 1) && (pt - (depth - 1) < n);
            quit_enable       = use_quit && (pt == last_pt);
            for (int j = 0; j < k; j++) begin
                iter_start_block = 1'b1; iter_end_block = 1'b1; quit_block = 1'b1;
                step();
            end
            iter_start_block = 1'b0; iter_end_block = 1'b0; quit_block = 1'b0;
            step();
            if (pt == mid_pt) begin
                ends = (pt >= depth - 1) ? (pt - depth + 2) : 0;
                expect_val("mid_iter_start", S_ITER_START, 32'(pt + 1));
                expect_val("mid_iter_end", S_ITER_END, 32'(ends));
                expect_val("mid_in_flight", S_IN_FLIGHT, 32'(pt + 1 - ends));
                expect_val("mid_stall", S_STALL, 32'(mid_stalls));
                expect_val("mid_loop_active", S_LOOP_ACTIVE, 32'd1);
                checkpoint();
            end
        end
        idle();
        if (!use_quit) begin
            loop_done = 1'b1;
            step();
            loop_done = 1'b0;
        end
        step();
    endtask

    initial begin : stimulus
        idle();
        // Reset held two cycles while inputs toggle.
        reset = 1'b0;
        ap_start = 1'b1; ap_done = 1'b1; cur_state = 1'b1; iter_start_enable = 1'b1;
        iter_end_enable = 1'b1; loop_start = 1'b1; finish = 1'b1;
        step();
        ap_start = 1'b0; ap_done = 1'b0; iter_start_block = 1'b1; iter_start_enable = 1'b0;
        loop_start = 1'b0; finish = 1'b0; loop_done = 1'b1;
        step();
        expect_all_zero("in_reset");
        idle();
        reset = 1'b1;
        step();
        step();
        expect_all_zero("after_reset");

        // Transaction: start at cycle 0, done at cycle 9 -> latency 10.
        lat_q.push_back(32'd10);
        ap_start = 1'b1; ap_ready = 1'b1;
        step();
        ap_start = 1'b0; ap_ready = 1'b0;
        repeat (4) step();
        expect_val("txn_busy_active", S_TXN_ACTIVE, 32'd1);
        expect_val("txn_busy_cnt", S_TXN_CNT, 32'd0);
        checkpoint();
        repeat (4) step();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        step();
        expect_val("txn1_cnt", S_TXN_CNT, 32'd1);
        expect_val("txn1_max", S_MAX_LAT, 32'd10);
        expect_val("txn1_active", S_TXN_ACTIVE, 32'd0);
        checkpoint();

        // Second transaction latency 4; max stays 10.
        lat_q.push_back(32'd4);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        repeat (2) step();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        step();
        expect_val("txn2_cnt", S_TXN_CNT, 32'd2);
        expect_val("txn2_last", S_LAST_LAT, 32'd4);
        expect_val("txn2_max", S_MAX_LAT, 32'd10);
        checkpoint();

        // Start and done in the same cycle -> latency 1, never active.
        lat_q.push_back(32'd1);
        ap_start = 1'b1; ap_done = 1'b1;
        step();
        ap_start = 1'b0; ap_done = 1'b0;
        expect_val("txn3_active", S_TXN_ACTIVE, 32'd0);
        expect_val("txn3_cnt", S_TXN_CNT, 32'd3);
        expect_val("txn3_last", S_LAST_LAT, 32'd1);
        expect_val("txn3_max", S_MAX_LAT, 32'd10);
        expect_val("txn3_perr", S_PERR, 32'd0);
        checkpoint();

        // 32 iterations, depth 34, 3 blocked cycles, exit via quit.
        run_loop(32, 34, 10, 10, 40, 1'b1, 19, 2);
        expect_val("loop1_iter_start", S_ITER_START, 32'd32);
        expect_val("loop1_iter_end", S_ITER_END, 32'd32);
        expect_val("loop1_stall", S_STALL, 32'd3);
        expect_val("loop1_inv", S_LOOP_INV, 32'd1);
        expect_val("loop1_in_flight", S_IN_FLIGHT, 32'd0);
        expect_val("loop1_active", S_LOOP_ACTIVE, 32'd0);
        expect_val("loop1_perr", S_PERR, 32'd0);
        expect_val("w4_iter_start_sat", S_W4_START, 32'd15);
        checkpoint();

        // Iteration end with nothing in flight.
        cur_state = 1'b1; iter_end_enable = 1'b1;
        step();
        idle();
        step();
        expect_val("orphan_end_perr", S_PERR, 32'd1);
        expect_val("orphan_end_iter_end", S_ITER_END, 32'd32);
        expect_val("orphan_end_in_flight", S_IN_FLIGHT, 32'd0);
        checkpoint();
        repeat (3) step();
        expect_val("perr_sticky", S_PERR, 32'd1);
        checkpoint();

        // Finish mid-transaction, then further events must not change anything.
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        repeat (2) step();
        finish = 1'b1;
        step();
        finish = 1'b0;
        ap_done = 1'b1;
        step();
        ap_done = 1'b0; ap_start = 1'b1; loop_start = 1'b1;
        step();
        idle();
        cur_state = 1'b1; iter_start_enable = 1'b1;
        repeat (2) step();
        iter_start_block = 1'b1;
        step();
        idle();
        step();
        expect_val("frz_frozen", S_FROZEN, 32'd1);
        expect_val("frz_txn_active", S_TXN_ACTIVE, 32'd1);
        expect_val("frz_txn_cnt", S_TXN_CNT, 32'd3);
        expect_val("frz_last", S_LAST_LAT, 32'd1);
        expect_val("frz_max", S_MAX_LAT, 32'd10);
        expect_val("frz_iter_start", S_ITER_START, 32'd32);
        expect_val("frz_iter_end", S_ITER_END, 32'd32);
        expect_val("frz_loop_active", S_LOOP_ACTIVE, 32'd0);
        expect_val("frz_loop_inv", S_LOOP_INV, 32'd1);
        expect_val("frz_stall", S_STALL, 32'd3);
        expect_val("frz_perr", S_PERR, 32'd1);
        checkpoint();

        // Reset clears frozen/protocol_err; 20-iteration loop exits via loop_done.
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        expect_val("rst2_frozen", S_FROZEN, 32'd0);
        expect_val("rst2_perr", S_PERR, 32'd0);
        expect_val("rst2_txn_cnt", S_TXN_CNT, 32'd0);
        expect_val("rst2_txn_active", S_TXN_ACTIVE, 32'd0);
        expect_val("rst2_max", S_MAX_LAT, 32'd0);
        checkpoint();
        run_loop(20, 3, -1, -1, -1, 1'b0, 5, 0);
        expect_val("loop2_iter_start", S_ITER_START, 32'd20);
        expect_val("loop2_iter_end", S_ITER_END, 32'd20);
        expect_val("loop2_in_flight", S_IN_FLIGHT, 32'd0);
        expect_val("loop2_inv", S_LOOP_INV, 32'd1);
        expect_val("loop2_active", S_LOOP_ACTIVE, 32'd0);
        expect_val("loop2_stall", S_STALL, 32'd0);
        expect_val("loop2_perr", S_PERR, 32'd0);
        expect_val("w4_20_iter_start_sat", S_W4_START, 32'd15);
        checkpoint();

        // Stray ap_done with no transaction and no start.
        ap_done = 1'b1;
        step();
        idle();
        step();
        expect_val("stray_done_perr", S_PERR, 32'd1);
        expect_val("stray_done_txn_cnt", S_TXN_CNT, 32'd0);
        expect_val("stray_done_active", S_TXN_ACTIVE, 32'd0);
        expect_val("latq_drained", S_LATQ_LEFT, 32'd0);
        checkpoint();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
